// File: rtl/fifo_rr_share_pkg.sv
// fifo_rr_pkg: shared types and helpers for the fifo_rr_share block.
//   arb_state_e  - arbiter state (IDLE / LOCKED)
//   DEPTH        - number of entries in the output buffer
//   pack_entry   - builds an entry {src_id, last, data} from its fields
//   entry_src / entry_last / entry_data - pull fields back out of an entry
// Entries are handled as a wide vector and shifted by the runtime widths so
// one set of helpers serves every (idw, width) combination; callers cast the
// result down to their real entry width.
package fifo_rr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEPTH   = 2;
    localparam int ENT_MAX = 64;

    typedef logic [ENT_MAX-1:0] ent_vec_t;

    function automatic ent_vec_t field_mask(input int unsigned w);
        return (ent_vec_t'(1) << w) - ent_vec_t'(1);
    endfunction

    function automatic ent_vec_t pack_entry(input int unsigned idw,
                                            input int unsigned width,
                                            input ent_vec_t    src,
                                            input logic        last,
                                            input ent_vec_t    data);
        return ((src & field_mask(idw)) << (width + 1))
             | (ent_vec_t'(last) << width)
             | (data & field_mask(width));
    endfunction

    function automatic ent_vec_t entry_src(input int unsigned idw,
                                           input int unsigned width,
                                           input ent_vec_t    e);
        return (e >> (width + 1)) & field_mask(idw);
    endfunction

    function automatic logic entry_last(input int unsigned width,
                                        input ent_vec_t    e);
        ent_vec_t s;
        s = e >> width;
        return s[0];
    endfunction

    function automatic ent_vec_t entry_data(input int unsigned width,
                                            input ent_vec_t    e);
        return e & field_mask(width);
    endfunction

endpackage

// File: rtl/fifo_rr_share_if.sv
// fifo_rr_share_if: producer side and consumer side of the shared queue.
//   REQ_VALID/REQ_DATA/REQ_LAST/REQ_READY - per-requester beat handshake
//   D_OUT/EMPTY_N/DEQ                     - head entry and pop
//   CLR                                   - synchronous flush
// slave modport is the block, master modport is its environment.
interface fifo_rr_share_if #(
    parameter int width = 8,
    parameter int nreq  = 4,
    parameter int idw   = 2
);
    logic [nreq-1:0]       REQ_VALID;
    logic [nreq*width-1:0] REQ_DATA;
    logic [nreq-1:0]       REQ_LAST;
    logic [nreq-1:0]       REQ_READY;
    logic [idw+width:0]    D_OUT;
    logic                  EMPTY_N;
    logic                  DEQ;
    logic                  CLR;

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, DEQ, CLR,
        output REQ_READY, D_OUT, EMPTY_N
    );

    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, DEQ, CLR,
        input  REQ_READY, D_OUT, EMPTY_N
    );
endinterface

// File: rtl/fifo_rr_buf.sv
// fifo_rr_buf: two-entry register queue.
//   clk_i, rst_i (sync, active high), clr_i (sync flush)
//   enq_i/din_i  - push an entry (caller never pushes when full_o)
//   deq_i        - pop head; ignored when empty
//   dout_o       - head entry, empty_n_o - head valid, full_o - both slots used
// Push and pop together with one entry held replaces the head directly.
module fifo_rr_buf
    import fifo_rr_pkg::*;
#(
    parameter int DW = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          enq_i,
    input  logic          deq_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_n_o
);
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          push, pop;

    assign push = enq_i && (cnt_q != FULL_CNT);
    assign pop  = deq_i && (cnt_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: if (push) begin
                head_d = din_i;
                cnt_d  = 2'd1;
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = din_i;
                end else if (push) begin
                    tail_d = din_i;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            2'd2: if (pop) begin
                head_d = tail_q;
                cnt_d  = 2'd1;
            end
            default: cnt_d = 2'd0;
        endcase
        if (clr_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_o    = head_q;
    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_n_o = (cnt_q != 2'd0);
endmodule

// File: rtl/fifo_rr_share.sv
// fifo_rr_share: round-robin arbiter feeding a shared two-entry queue.
//   CLK, RST (sync, active high) - plain ports
//   bus (slave)                  - requester beats in, {src_id,last,data} out
// In IDLE the first valid requester at or after ptr wins; a beat without
// last locks the grant to that owner until its last beat is taken.
// REQ_READY only looks at the registered full flag, so DEQ never reaches it
// combinationally.
module fifo_rr_share
    import fifo_rr_pkg::*;
#(
    parameter int width = 8,
    parameter int nreq  = 4,
    parameter int idw   = 2
) (
    input  logic            CLK,
    input  logic            RST,
    fifo_rr_share_if.slave  bus
);
    localparam int ENTW = idw + 1 + width;

    arb_state_e       state_q, state_d;
    logic [idw-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [idw-1:0]   sel, sel_nxt;
    logic [idw:0]     cand;
    logic             found, space, full, xfer, sel_last;
    logic [nreq-1:0]  ready;
    logic [width-1:0] sel_data;
    logic [ENTW-1:0]  din;

    assign space = !full && !RST && !bus.CLR;

    // Grant select: owner when locked, else cyclic search starting at ptr.
    always_comb begin
        ready = '0;
        sel   = owner_q;
        found = 1'b0;
        cand  = '0;
        if (state_q == LOCKED) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < nreq; k++) begin
                cand = {1'b0, ptr_q} + (idw+1)'(k);
                if (cand >= (idw+1)'(nreq)) cand = cand - (idw+1)'(nreq);
                if (!found && bus.REQ_VALID[cand[idw-1:0]]) begin
                    found = 1'b1;
                    sel   = cand[idw-1:0];
                end
            end
        end
        if (space && found) ready[sel] = 1'b1;
    end

    assign bus.REQ_READY = ready;
    assign xfer     = |(ready & bus.REQ_VALID);
    assign sel_last = bus.REQ_LAST[sel];
    assign sel_data = bus.REQ_DATA[int'(sel)*width +: width];
    assign sel_nxt  = (sel == idw'(nreq - 1)) ? '0 : sel + 1'b1;
    assign din      = ENTW'(pack_entry(idw, width, ent_vec_t'(sel), sel_last,
                                       ent_vec_t'(sel_data)));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (bus.CLR) begin
            state_d = IDLE;
            ptr_d   = '0;
            owner_d = '0;
        end else if (xfer) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = sel_nxt;
            end else begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    fifo_rr_buf #(.DW(ENTW)) u_buf (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (bus.CLR),
        .enq_i     (xfer),
        .deq_i     (bus.DEQ),
        .din_i     (din),
        .dout_o    (bus.D_OUT),
        .full_o    (full),
        .empty_n_o (bus.EMPTY_N)
    );

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge CLK) $onehot0(bus.REQ_READY))
        else $error("REQ_READY not one-hot-or-zero: %b", bus.REQ_READY);
    a_deq_empty: assert property (@(posedge CLK) disable iff (RST)
        !(bus.DEQ && !bus.EMPTY_N))
        else $warning("DEQ while queue empty");
    for (genvar i = 0; i < nreq; i++) begin : g_hold
        a_hold: assert property (@(posedge CLK) disable iff (RST || bus.CLR)
            (bus.REQ_VALID[i] && !bus.REQ_READY[i]) |=>
            (bus.REQ_VALID[i] && $stable(bus.REQ_DATA[i*width +: width])
             && $stable(bus.REQ_LAST[i])))
            else $warning("requester %0d changed a pending beat", i);
    end
`endif
endmodule

// File: tb/tb_fifo_rr_share.sv
// Bench for fifo_rr_share (nreq=4, width=8): reset checks, a vector table
// for rotation and packet locking, hand sequences for back-pressure, replace-
// head and flush, then randomized traffic against a queue-based model.
module tb_fifo_rr_share;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rr_share_if #(.width(8), .nreq(4), .idw(2)) bus ();
    fifo_rr_share #(.width(8), .nreq(4), .idw(2)) dut (
        .CLK (clk), .RST (rst), .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: output queue plus round-robin bookkeeping.
    logic [10:0] mq[$];
    int          m_ptr = 0, m_owner = 0;
    bit          m_locked = 0;
    logic [7:0]  dd[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_ready(input logic [3:0] v, input logic r, input logic c);
        if (r || c || mq.size() >= 2) return 4'b0;
        if (m_locked) return 4'(1 << m_owner);
        for (int k = 0; k < 4; k++)
            if (v[(m_ptr + k) % 4]) return 4'(1 << ((m_ptr + k) % 4));
        return 4'b0;
    endfunction

    // One clock: drive, check ready, clock the model, check queue outputs.
    task automatic cyc(input logic r, input logic c, input logic deq,
                       input logic [3:0] v, input logic [3:0] l, output logic [3:0] r_act);
        logic [3:0] er;
        int         g;
        rst = r;
        bus.CLR = c;
        bus.DEQ = deq;
        bus.REQ_VALID = v;
        bus.REQ_LAST = l;
        bus.REQ_DATA = {dd[3], dd[2], dd[1], dd[0]};
        #1;
        er = m_ready(v, r, c);
        r_act = bus.REQ_READY;
        check("ready_model", 32'(r_act), 32'(er));
        @(posedge clk);
        if (r || c) begin
            mq.delete();
            m_ptr = 0;
            m_locked = 0;
            m_owner = 0;
        end else begin
            if (deq && mq.size() > 0) void'(mq.pop_front());
            if ((er & v) != 0) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (er[i]) g = i;
                mq.push_back({2'(g), l[g], dd[g]});
                if (l[g]) begin
                    m_locked = 0;
                    m_ptr = (g + 1) % 4;
                end else begin
                    m_locked = 1;
                    m_owner = g;
                end
            end
        end
        #1;
        check("empty_n_model", 32'(bus.EMPTY_N), 32'(mq.size() > 0));
        if (mq.size() > 0) check("dout_model", 32'(bus.D_OUT), 32'(mq[0]));
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        deq;
        logic [3:0]  rdy;
        logic        en;
        logic [10:0] dout;
    } vec_t;

    vec_t       tbl[10];
    logic [3:0] ra;
    bit         pend[4];
    logic [3:0] lst;

    initial begin
        // rotation over single-beat packets, then a locked 3-beat packet from 2
        tbl[0] = '{4'hF, 4'hF, 1'b0, 4'b0001, 1'b1, 11'h1A0};
        tbl[1] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 11'h3A1};
        tbl[2] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 11'h5A2};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 11'h7A3};
        tbl[4] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 11'h1A0};
        tbl[5] = '{4'h4, 4'h0, 1'b1, 4'b0100, 1'b1, 11'h4A2};
        tbl[6] = '{4'hF, 4'hB, 1'b1, 4'b0100, 1'b1, 11'h4A2};
        tbl[7] = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 11'h5A2};
        tbl[8] = '{4'hB, 4'hF, 1'b1, 4'b1000, 1'b1, 11'h7A3};
        tbl[9] = '{4'hB, 4'hF, 1'b1, 4'b0001, 1'b1, 11'h1A0};
        for (int i = 0; i < 4; i++) dd[i] = 8'hA0 + 8'(i);

        // reset: queue empty, no grants even with every requester valid
        cyc(1, 0, 0, 4'h0, 4'h0, ra);
        check("rst_empty_n", 32'(bus.EMPTY_N), 0);
        check("rst_dout", 32'(bus.D_OUT), 0);
        cyc(1, 0, 0, 4'hF, 4'hF, ra);
        check("rst_ready_held", 32'(ra), 0);

        for (int t = 0; t < 10; t++) begin
            cyc(0, 0, tbl[t].deq, tbl[t].v, tbl[t].l, ra);
            check($sformatf("tbl%0d_ready", t), 32'(ra), 32'(tbl[t].rdy));
            check($sformatf("tbl%0d_empty_n", t), 32'(bus.EMPTY_N), 32'(tbl[t].en));
            check($sformatf("tbl%0d_dout", t), 32'(bus.D_OUT), 32'(tbl[t].dout));
        end

        // back-pressure: two beats fill the queue, one DEQ frees one slot
        cyc(0, 0, 1, 4'h0, 4'h0, ra);
        dd[1] = 8'hB0; cyc(0, 0, 0, 4'h2, 4'h2, ra);
        dd[1] = 8'hB1; cyc(0, 0, 0, 4'h2, 4'h2, ra);
        dd[1] = 8'hB2; cyc(0, 0, 0, 4'h2, 4'h2, ra);
        check("full_stall", 32'(ra), 0);
        cyc(0, 0, 1, 4'h2, 4'h2, ra);
        check("full_deq_no_ready", 32'(ra), 0);
        cyc(0, 0, 0, 4'h2, 4'h2, ra);
        check("one_more_accept", 32'(ra), 32'h2);
        check("order_head_b1", 32'(bus.D_OUT), 32'h3B1);
        cyc(0, 0, 1, 4'h0, 4'h0, ra);
        check("order_head_b2", 32'(bus.D_OUT), 32'h3B2);

        // one entry held: accept + DEQ replaces the head
        dd[1] = 8'hC0; cyc(0, 0, 1, 4'h2, 4'h2, ra);
        check("swap_empty_n", 32'(bus.EMPTY_N), 1);
        check("swap_dout", 32'(bus.D_OUT), 32'h3C0);
        cyc(0, 0, 1, 4'h0, 4'h0, ra);
        check("swap_occ_one", 32'(bus.EMPTY_N), 0);

        // flush mid-packet while owner=1 holds both entries
        dd[1] = 8'hD0; cyc(0, 0, 0, 4'h2, 4'h0, ra);
        dd[1] = 8'hD1; cyc(0, 0, 0, 4'h2, 4'h0, ra);
        dd[1] = 8'hD2; dd[0] = 8'hE0;
        cyc(0, 1, 0, 4'h3, 4'h1, ra);
        check("clr_ready", 32'(ra), 0);
        check("clr_empty_n", 32'(bus.EMPTY_N), 0);
        cyc(0, 0, 0, 4'h3, 4'h1, ra);
        check("clr_ptr0_grant", 32'(ra), 32'h1);
        cyc(0, 0, 1, 4'h2, 4'h0, ra);
        check("clr_lock_dropped", 32'(ra), 32'h2);
        cyc(0, 0, 1, 4'h0, 4'h0, ra);

        // randomized traffic; pending beats hold until accepted
        for (int i = 0; i < 4; i++) pend[i] = 0;
        lst = 4'h0;
        for (int n = 0; n < 600; n++) begin
            logic [3:0] v;
            logic       c, d;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1;
                    dd[i]   = 8'($urandom);
                    lst[i]  = ($urandom % 2 == 0);
                end
                v[i] = pend[i];
            end
            c = ($urandom % 60 == 0);
            d = ($urandom % 2 == 0) && (mq.size() > 0);
            cyc(0, c, d, v, lst, ra);
            for (int i = 0; i < 4; i++) if (ra[i] && v[i]) pend[i] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
